// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT result write-back path.
`timescale 1ns/1ps
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    // Result words are 32-bit, so consecutive words are 4 bytes apart.
    localparam int WORD_SHIFT = 2;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/wb_addr_gen.sv
// Word index register plus shift-and-add producing the byte address of the
// next word to be accepted.
`timescale 1ns/1ps
module wb_addr_gen
    import fft_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] idx,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // The shift drops the top index bits and the sum wraps modulo 2^ADDR_W.
    assign idx  = idx_q;
    assign addr = base + (idx_q << WORD_SHIFT);

endmodule

// File: rtl/fft_writeback_ctrl.sv
// Writes FFT result words to memory at offset + 4*index, holding each write
// until acknowledged, and flags done after filesize words have been written.
`timescale 1ns/1ps
module fft_writeback_ctrl
    import fft_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              pause,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] filesize,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output wb_state_t         dbg_state
);

    // Input handshake: a word transfers in any cycle with in_valid && in_ready;
    // memory handshake: mem_we/mem_addr/mem_wdata hold until a cycle with mem_ack.

    wb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] filesize_q, filesize_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start;
    logic              accept;
    logic              wr_fire;
    logic [ADDR_W-1:0] acc_cnt;
    logic [ADDR_W-1:0] next_addr;

    assign start   = enable && (state_q == IDLE || state_q == DONE);
    assign wr_fire = mem_we_q && mem_ack;
    // A new word may enter in the same cycle the pending write is acknowledged.
    assign in_ready = (state_q == RUN) && !pause && (acc_cnt < filesize_q)
                      && (!mem_we_q || mem_ack);
    assign accept  = in_valid && in_ready;

    wb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (accept),
        .base  (offset_q),
        .idx   (acc_cnt),
        .addr  (next_addr)
    );

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        filesize_d  = filesize_q;
        wr_cnt_d    = wr_cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (enable) begin
                    offset_d   = offset;
                    filesize_d = filesize;
                    wr_cnt_d   = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (wr_fire) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
                if (wr_cnt_q == filesize_q && !mem_we_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = next_addr;
            mem_wdata_d = in_data;
        end else if (wr_fire) begin
            mem_we_d = 1'b0;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            filesize_q  <= '0;
            wr_cnt_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            filesize_q  <= filesize_d;
            wr_cnt_q    <= wr_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_writeback_ctrl.sv
// Directed bench for fft_writeback_ctrl: full-rate runs, backpressure, pause,
// zero size, address wrap, ignored restart and mid-run reset.
`timescale 1ns/1ps
module tb_fft_writeback_ctrl;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pause;
    logic [31:0] offset;
    logic [31:0] filesize;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    wb_state_t   dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int ack_count = 0;
    int ack_base;

    fft_writeback_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pause     (pause),
        .offset    (offset),
        .filesize  (filesize),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Independent count of completed memory writes.
    always @(posedge clk) begin
        if (rst_n && mem_we && mem_ack) ack_count <= ack_count + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks run 1ns later.
    task automatic nxt();
        @(negedge clk);
    endtask

    function automatic logic [31:0] word(input logic [31:0] off, input int i);
        return 32'hA5000000 ^ off ^ (i * 32'h01010101);
    endfunction

    // Full-rate run: in_valid and mem_ack held high, one write per cycle.
    task automatic full_run(input logic [31:0] off, input int n);
        logic [31:0] exp_addr;
        nxt();
        enable = 1'b1; offset = off; filesize = n; in_valid = 1'b1;
        mem_ack = 1'b1; pause = 1'b0; in_data = word(off, 0);
        ack_base = ack_count;
        nxt();
        enable = 1'b0;
        #1 chk("run_busy", busy, 1'b1);
        chk("run_ready", in_ready, 1'b1);
        for (int i = 0; i < n; i++) begin
            nxt();
            in_data = word(off, i + 1);
            exp_addr = off + 32'(i * 4);
            #1 chk("run_we", mem_we, 1'b1);
            chk("run_addr", mem_addr, exp_addr);
            chk("run_wdata", mem_wdata, word(off, i));
        end
        nxt();
        #1 chk("run_we_off", mem_we, 1'b0);
        chk("run_not_done", done, 1'b0);
        chk("run_still_busy", busy, 1'b1);
        nxt();
        #1 chk("run_done", done, 1'b1);
        chk("run_idle_busy", busy, 1'b0);
        chk("run_count", 64'(ack_count - ack_base), 64'(n));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; pause = 1'b0; offset = '0; filesize = '0;
        in_valid = 1'b0; in_data = '0; mem_ack = 1'b0;
        repeat (3) nxt();
        #1 chk("rst_state", 64'(dbg_state), 64'(IDLE));
        chk("rst_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        nxt();
        rst_n = 1'b1;
        in_valid = 1'b1; mem_ack = 1'b1;
        #1 chk("idle_no_ready", in_ready, 1'b0);

        // Basic run at 0x1000, addresses 0x1000..0x100C.
        full_run(32'h0000_1000, 4);

        // Backpressure: ack held low for 3 cycles on the second word.
        nxt();
        enable = 1'b1; offset = 32'h2000; filesize = 4; in_data = 32'h11;
        ack_base = ack_count;
        nxt();
        enable = 1'b0;
        nxt();
        in_data = 32'h22;
        #1 chk("bp_addr0", mem_addr, 32'h2000);
        nxt();
        mem_ack = 1'b0; in_data = 32'h33;
        #1 chk("bp_addr1", mem_addr, 32'h2004);
        for (int i = 0; i < 2; i++) begin
            nxt();
            #1 chk("bp_hold_addr", mem_addr, 32'h2004);
            chk("bp_hold_data", mem_wdata, 32'h22);
            chk("bp_hold_we", mem_we, 1'b1);
            chk("bp_no_ready", in_ready, 1'b0);
        end
        nxt();
        mem_ack = 1'b1;
        #1 chk("bp_ready_on_ack", in_ready, 1'b1);
        chk("bp_still_addr1", mem_addr, 32'h2004);
        nxt();
        in_data = 32'h44;
        #1 chk("bp_addr2", mem_addr, 32'h2008);
        chk("bp_data2", mem_wdata, 32'h33);
        nxt();
        #1 chk("bp_addr3", mem_addr, 32'h200C);
        chk("bp_data3", mem_wdata, 32'h44);
        chk("bp_full", in_ready, 1'b0);
        nxt(); nxt();
        #1 chk("bp_done", done, 1'b1);
        chk("bp_count", 64'(ack_count - ack_base), 64'd4);

        // Pause with the second write pending.
        nxt();
        enable = 1'b1; offset = 32'h3000; filesize = 4; in_data = 32'h51;
        ack_base = ack_count;
        nxt();
        enable = 1'b0;
        nxt();
        in_data = 32'h52;
        nxt();
        pause = 1'b1; mem_ack = 1'b0; in_data = 32'h53;
        #1 chk("pz_pending", mem_we, 1'b1);
        chk("pz_addr1", mem_addr, 32'h3004);
        chk("pz_no_ready", in_ready, 1'b0);
        nxt();
        mem_ack = 1'b1;
        #1 chk("pz_no_ready_ack", in_ready, 1'b0);
        nxt();
        #1 chk("pz_write_done", mem_we, 1'b0);
        chk("pz_busy", busy, 1'b1);
        chk("pz_held", in_ready, 1'b0);
        nxt();
        pause = 1'b0;
        #1 chk("pz_resume", in_ready, 1'b1);
        nxt();
        in_data = 32'h54;
        #1 chk("pz_addr2", mem_addr, 32'h3008);
        chk("pz_data2", mem_wdata, 32'h53);
        nxt();
        #1 chk("pz_addr3", mem_addr, 32'h300C);
        nxt(); nxt();
        #1 chk("pz_done", done, 1'b1);
        chk("pz_count", 64'(ack_count - ack_base), 64'd4);

        // Zero size: one RUN cycle with no write, then DONE.
        nxt();
        enable = 1'b1; offset = 32'h4000; filesize = 0;
        ack_base = ack_count;
        nxt();
        enable = 1'b0;
        #1 chk("z_busy", busy, 1'b1);
        chk("z_done_cleared", done, 1'b0);
        chk("z_ready", in_ready, 1'b0);
        chk("z_we", mem_we, 1'b0);
        nxt();
        #1 chk("z_done", done, 1'b1);
        chk("z_we_after", mem_we, 1'b0);
        chk("z_count", 64'(ack_count - ack_base), 64'd0);

        // Address wrap: 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
        full_run(32'hFFFF_FFF8, 3);

        // Enable mid-run ignored, then reset mid-run.
        nxt();
        enable = 1'b1; offset = 32'h5000; filesize = 4; in_data = 32'h61;
        nxt();
        enable = 1'b0; mem_ack = 1'b0;
        nxt();
        enable = 1'b1; offset = 32'h6000;
        #1 chk("rs_addr0", mem_addr, 32'h5000);
        nxt();
        enable = 1'b0;
        #1 chk("rs_ignored_addr", mem_addr, 32'h5000);
        chk("rs_ignored_state", 64'(dbg_state), 64'(RUN));
        rst_n = 1'b0;
        #1 chk("rs_we", mem_we, 1'b0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_addr", mem_addr, 32'h0);
        chk("rs_wdata", mem_wdata, 32'h0);
        chk("rs_ready", in_ready, 1'b0);
        chk("rs_state", 64'(dbg_state), 64'(IDLE));
        nxt();
        rst_n = 1'b1;
        nxt();
        #1 chk("rs_stays_idle", 64'(dbg_state), 64'(IDLE));
        full_run(32'h0000_7000, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
